// File: rtl/self_checker_pkg.sv
// Shared encodings and helpers for the multi-channel golden-vector result checker.
package self_checker_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RUNNING = 3'd1;
   localparam logic [2:0] ST_PASS    = 3'd2;
   localparam logic [2:0] ST_FAIL    = 3'd4;
   localparam logic [2:0] ST_TIMEOUT = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   function automatic int tree_lat(input int dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

   function automatic int cmp_lat(input int dw);
      return 2 + tree_lat(dw);
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/self_checker_multi_or_reduce_pipe.sv
// Registered binary OR tree: one register level per tree level, input zero-padded
// to the next power of two, valid carried alongside with the same latency.
module or_reduce_pipe
   import self_checker_pkg::*;
#(
   parameter int DW  = 64,
   parameter int LAT = tree_lat(DW)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic          o_any
);

   localparam int P = 1 << LAT;

   // Heap layout: node i has children 2i+1 and 2i+2; leaves sit at P-1 .. 2P-2.
   logic [P-1:0]   leaf;
   logic [P-2:0]   node;
   logic [2*P-2:0] heap;
   logic [LAT-1:0] vld;

   assign leaf = P'(i_data);
   assign heap = {leaf, node};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         node <= '0;
         vld  <= '0;
      end else begin
         for (int i = 0; i < P - 1; i++) begin
            node[i] <= heap[2*i+1] | heap[2*i+2];
         end
         vld[0] <= i_valid;
         for (int i = 1; i < LAT; i++) begin
            vld[i] <= vld[i-1];
         end
      end
   end

   assign o_valid = vld[LAT-1];
   assign o_any   = heap[0];

endmodule

// File: rtl/self_checker_multi.sv
// Per-channel golden-vector comparator with masked compare, mismatch accounting,
// first-failure capture, overrun detection, stall watchdog and a frozen final report.
module self_checker_multi
   import self_checker_pkg::*;
#(
   parameter int NCH            = 2,
   parameter int DW             = 1024,
   parameter int NUM_VECTORS    = 512,
   parameter int ADDRW          = $clog2(NUM_VECTORS),
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int TREE_LAT       = tree_lat(DW)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_start,
   input  logic                  i_mask_en,
   input  logic [DW-1:0]         i_mask,
   input  logic                  i_res_valid,
   input  logic [NCH*DW-1:0]     i_res_data,
   output logic [ADDRW-1:0]      o_gold_addr,
   input  logic [NCH*DW-1:0]     i_gold_data,
   output logic [2:0]            o_status,
   output logic                  o_done,
   output logic [NCH-1:0]        o_ch_fail,
   output logic [31:0]           o_mismatch_count,
   output logic [ADDRW-1:0]      o_first_fail_idx,
   output logic [idx_w(NCH)-1:0] o_first_fail_ch,
   output logic [31:0]           o_result_count,
   output logic [31:0]           o_perf_counter,
   output state_t                o_dbg_state
);

   localparam int CHW     = idx_w(NCH);
   localparam int CMP_LAT = 2 + TREE_LAT;

   state_t            state_q, state_d;
   logic              start_run, accept, wd_fire, retire;
   logic [ADDRW:0]    acc_cnt;
   logic [31:0]       wd_q;
   logic [7:0]        drain_cnt;
   logic              timeout_q, overrun_q, mask_en_q, ff_valid;
   logic [31:0]       mm_q, rc_q, perf_q;
   logic [NCH-1:0]    ch_fail_q;
   logic [ADDRW-1:0]  ff_idx_q;
   logic [CHW-1:0]    ff_ch_q;

   logic              s1_valid, s2_valid;
   logic [ADDRW-1:0]  s1_idx, s2_idx;
   logic [NCH*DW-1:0] s1_data, s2_diff;
   logic [DW-1:0]     mask_eff;
   logic [ADDRW-1:0]  idx_sr [TREE_LAT];
   logic [NCH-1:0]    pipe_valid, fail_bits;
   logic [31:0]       pop;
   logic [CHW-1:0]    first_ch;

   // i_res_valid carries no back-pressure: a result is taken on every RUN cycle it
   // is high, flagged as an overrun in DRAIN, and dropped in IDLE/REPORT.
   assign accept  = i_res_valid && (state_q == S_RUN);
   assign wd_fire = (TIMEOUT_CYCLES != 0) && (state_q == S_RUN) && !i_res_valid &&
                    (wd_q == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      start_run = 1'b0;
      case (state_q)
         S_IDLE, S_REPORT: begin
            if (i_start) begin
               state_d   = S_RUN;
               start_run = 1'b1;
            end
         end
         S_RUN: begin
            if ((accept && acc_cnt == (ADDRW+1)'(NUM_VECTORS - 1)) || wd_fire)
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_cnt == 8'(CMP_LAT - 1)) state_d = S_REPORT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Compare pipeline: gold q for the result accepted at t lines up with s1 at t+1.
   assign mask_eff = mask_en_q ? i_mask : '1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_data  <= '0;
         s2_valid <= 1'b0;
         s2_idx   <= '0;
         s2_diff  <= '0;
         for (int k = 0; k < TREE_LAT; k++) idx_sr[k] <= '0;
      end else begin
         s1_valid <= accept;
         s1_idx   <= acc_cnt[ADDRW-1:0];
         s1_data  <= i_res_data;
         s2_valid <= s1_valid;
         s2_idx   <= s1_idx;
         s2_diff  <= (s1_data ^ i_gold_data) & {NCH{mask_eff}};
         idx_sr[0] <= s2_idx;
         for (int k = 1; k < TREE_LAT; k++) idx_sr[k] <= idx_sr[k-1];
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      or_reduce_pipe #(
         .DW  (DW),
         .LAT (TREE_LAT)
      ) u_or (
         .clk     (clk),
         .reset_n (reset_n),
         .i_valid (s2_valid),
         .i_data  (s2_diff[c*DW +: DW]),
         .o_valid (pipe_valid[c]),
         .o_any   (fail_bits[c])
      );
   end

   assign retire = (&pipe_valid) && (state_q == S_RUN || state_q == S_DRAIN);

   always_comb begin
      pop      = '0;
      first_ch = '0;
      for (int c = 0; c < NCH; c++) pop = pop + 32'(fail_bits[c]);
      for (int c = NCH - 1; c >= 0; c--) begin
         if (fail_bits[c]) first_ch = CHW'(c);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_cnt   <= '0;
         wd_q      <= '0;
         drain_cnt <= '0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         mask_en_q <= 1'b0;
         ff_valid  <= 1'b0;
         mm_q      <= '0;
         rc_q      <= '0;
         perf_q    <= '0;
         ch_fail_q <= '0;
         ff_idx_q  <= '0;
         ff_ch_q   <= '0;
      end else if (start_run) begin
         acc_cnt   <= '0;
         wd_q      <= '0;
         drain_cnt <= '0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         mask_en_q <= i_mask_en;
         ff_valid  <= 1'b0;
         mm_q      <= '0;
         rc_q      <= '0;
         perf_q    <= '0;
         ch_fail_q <= '0;
         ff_idx_q  <= '0;
         ff_ch_q   <= '0;
      end else begin
         if (accept) begin
            acc_cnt <= acc_cnt + (ADDRW+1)'(1);
            rc_q    <= rc_q + 32'd1;
            wd_q    <= '0;
         end else if (state_q == S_RUN) begin
            wd_q <= wd_q + 32'd1;
         end
         if (wd_fire) timeout_q <= 1'b1;
         if (state_q == S_DRAIN) begin
            drain_cnt <= drain_cnt + 8'd1;
            if (i_res_valid) overrun_q <= 1'b1;
         end
         if (state_q == S_RUN || state_q == S_DRAIN) perf_q <= perf_q + 32'd1;
         if (retire) begin
            mm_q      <= sat_add32(mm_q, pop);
            ch_fail_q <= ch_fail_q | fail_bits;
            if (!ff_valid && (|fail_bits)) begin
               ff_valid <= 1'b1;
               ff_idx_q <= idx_sr[TREE_LAT-1];
               ff_ch_q  <= first_ch;
            end
         end
      end
   end

   always_comb begin
      o_status = ST_IDLE;
      case (state_q)
         S_RUN, S_DRAIN: o_status = ST_RUNNING;
         S_REPORT: begin
            if (timeout_q)                         o_status = ST_TIMEOUT;
            else if (mm_q != 32'd0 || overrun_q)   o_status = ST_FAIL;
            else                                   o_status = ST_PASS;
         end
         default: o_status = ST_IDLE;
      endcase
   end

   assign o_done           = (state_q == S_REPORT);
   assign o_gold_addr      = acc_cnt[ADDRW-1:0];
   assign o_ch_fail        = ch_fail_q;
   assign o_mismatch_count = mm_q;
   assign o_first_fail_idx = ff_idx_q;
   assign o_first_fail_ch  = ff_ch_q;
   assign o_result_count   = rc_q;
   assign o_perf_counter   = perf_q;
   assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_self_checker_multi.sv
// Directed bench for self_checker_multi: a synchronous golden ROM model feeds the DUT,
// each run pushes its hand-derived report into a queue, a monitor checks it at o_done.
module tb_self_checker_multi;
   import self_checker_pkg::*;

   localparam int NCH     = 2;
   localparam int DW      = 64;
   localparam int NV      = 8;
   localparam int AW      = 3;
   localparam int TO      = 16;
   localparam int CMP_LAT = 8;   // 2 + log2(64)

   typedef struct packed {
      logic [2:0]  status;
      logic [1:0]  ch_fail;
      logic [31:0] mm;
      logic [2:0]  ff_idx;
      logic [0:0]  ff_ch;
      logic [31:0] rc;
      logic [31:0] perf;
      int          done_lo;
      int          done_hi;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              i_start = 1'b0;
   logic              i_mask_en = 1'b0;
   logic [DW-1:0]     i_mask = '1;
   logic              i_res_valid = 1'b0;
   logic [NCH*DW-1:0] i_res_data = '0;
   logic [NCH*DW-1:0] i_gold_data = '0;
   logic [AW-1:0]     o_gold_addr;
   logic [2:0]        o_status;
   logic              o_done;
   logic [NCH-1:0]    o_ch_fail;
   logic [31:0]       o_mismatch_count;
   logic [AW-1:0]     o_first_fail_idx;
   logic [0:0]        o_first_fail_ch;
   logic [31:0]       o_result_count;
   logic [31:0]       o_perf_counter;
   state_t            o_dbg_state;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_acc = 0;
   exp_t exp_q[$];
   exp_t e;
   logic done_prev = 1'b0;
   logic [DW-1:0] err [NCH][NV];

   self_checker_multi #(
      .NCH            (NCH),
      .DW             (DW),
      .NUM_VECTORS    (NV),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_start          (i_start),
      .i_mask_en        (i_mask_en),
      .i_mask           (i_mask),
      .i_res_valid      (i_res_valid),
      .i_res_data       (i_res_data),
      .o_gold_addr      (o_gold_addr),
      .i_gold_data      (i_gold_data),
      .o_status         (o_status),
      .o_done           (o_done),
      .o_ch_fail        (o_ch_fail),
      .o_mismatch_count (o_mismatch_count),
      .o_first_fail_idx (o_first_fail_idx),
      .o_first_fail_ch  (o_first_fail_ch),
      .o_result_count   (o_result_count),
      .o_perf_counter   (o_perf_counter),
      .o_dbg_state      (o_dbg_state)
   );

   // ---------------- clock / reset / ROM model ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] gold_word(input int a, input int c);
      return {32'hA5A5_0000 | 32'(a * 16 + c), 32'h1234_5678 ^ 32'(a * 7 + c * 3)};
   endfunction

   always @(posedge clk)
      i_gold_data <= {gold_word(int'(o_gold_addr), 1), gold_word(int'(o_gold_addr), 0)};

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_err();
      for (int c = 0; c < NCH; c++)
         for (int v = 0; v < NV; v++) err[c][v] = '0;
   endtask

   task automatic start_run(input logic men, input logic [DW-1:0] msk);
      i_mask_en = men;
      i_mask    = msk;
      i_start   = 1'b1;
      tick();
      i_start   = 1'b0;
   endtask

   task automatic send_results(input int n, input int start_at);
      for (int v = 0; v < n; v++) begin
         i_res_valid = 1'b1;
         i_res_data  = {gold_word(v, 1) ^ err[1][v], gold_word(v, 0) ^ err[0][v]};
         i_start     = (v == start_at);
         last_acc    = cyc;
         tick();
      end
      i_res_valid = 1'b0;
      i_start     = 1'b0;
   endtask

   task automatic push_exp(input logic [2:0] st, input logic [1:0] chf, input int mm,
                           input int ffi, input int ffc, input int rc, input int perf,
                           input int lo, input int hi);
      exp_t x;
      x.status  = st;
      x.ch_fail = chf;
      x.mm      = 32'(mm);
      x.ff_idx  = 3'(ffi);
      x.ff_ch   = 1'(ffc);
      x.rc      = 32'(rc);
      x.perf    = 32'(perf);
      x.done_lo = lo;
      x.done_hi = hi;
      exp_q.push_back(x);
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!o_done && k < 200) begin
         tick();
         k++;
      end
      if (!o_done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: o_done not seen within 200 cycles", name);
      end
      tick();
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (o_done && !done_prev) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: o_done rose at cycle %0d, expected none", cyc);
         end else begin
            e = exp_q.pop_front();
            check("status",       64'(o_status),         64'(e.status));
            check("ch_fail",      64'(o_ch_fail),        64'(e.ch_fail));
            check("mismatch_cnt", 64'(o_mismatch_count), 64'(e.mm));
            check("first_idx",    64'(o_first_fail_idx), 64'(e.ff_idx));
            check("first_ch",     64'(o_first_fail_ch),  64'(e.ff_ch));
            check("result_cnt",   64'(o_result_count),   64'(e.rc));
            check("perf_cnt",     64'(o_perf_counter),   64'(e.perf));
            check_range("done_cycle", cyc, e.done_lo, e.done_hi);
         end
      end
      done_prev = o_done;
   end

   // ---------------- directed stimulus ----------------
   initial begin
      clear_err();
      repeat (3) @(posedge clk);
      #1;
      check("rst_status",    64'(o_status),         64'(ST_IDLE));
      check("rst_done",      64'(o_done),           64'd0);
      check("rst_rc",        64'(o_result_count),   64'd0);
      check("rst_mm",        64'(o_mismatch_count), 64'd0);
      check("rst_addr",      64'(o_gold_addr),      64'd0);
      check("rst_perf",      64'(o_perf_counter),   64'd0);
      check("rst_ch_fail",   64'(o_ch_fail),        64'd0);
      check("rst_dbg_state", 64'(o_dbg_state),      64'(S_IDLE));
      reset_n = 1'b1;
      tick();
      tick();

      // All results match golden.
      start_run(1'b0, '1);
      send_results(NV, -1);
      push_exp(ST_PASS, 2'b00, 0, 0, 0, 8, 16, last_acc + CMP_LAT + 1, last_acc + CMP_LAT + 1);
      wait_done("clean");

      // ch1 v3 bit 5 and ch0 v6 bit 63 flipped.
      clear_err();
      err[1][3] = 64'h20;
      err[0][6] = 64'h8000_0000_0000_0000;
      start_run(1'b0, '1);
      send_results(NV, -1);
      push_exp(ST_FAIL, 2'b11, 2, 3, 1, 8, 16, last_acc + CMP_LAT + 1, last_acc + CMP_LAT + 1);
      wait_done("two_errors");

      // Masked-out bit 5 error passes, unmasked it fails.
      clear_err();
      err[0][3] = 64'h20;
      start_run(1'b1, ~64'h20);
      send_results(NV, -1);
      push_exp(ST_PASS, 2'b00, 0, 0, 0, 8, 16, last_acc + CMP_LAT + 1, last_acc + CMP_LAT + 1);
      wait_done("masked");
      start_run(1'b0, ~64'h20);
      send_results(NV, -1);
      push_exp(ST_FAIL, 2'b01, 1, 3, 0, 8, 16, last_acc + CMP_LAT + 1, last_acc + CMP_LAT + 1);
      wait_done("unmasked");

      // Both channels fail at v2: lowest channel captured; later v7 failure ignored.
      clear_err();
      err[0][2] = 64'h1;
      err[1][2] = 64'h1;
      err[1][7] = 64'hFFFF;
      start_run(1'b0, '1);
      send_results(NV, -1);
      push_exp(ST_FAIL, 2'b11, 3, 2, 0, 8, 16, last_acc + CMP_LAT + 1, last_acc + CMP_LAT + 1);
      wait_done("same_index");

      // Ninth valid lands in DRAIN: overrun.
      clear_err();
      start_run(1'b0, '1);
      send_results(NV, -1);
      push_exp(ST_FAIL, 2'b00, 0, 0, 0, 8, 16, last_acc + CMP_LAT + 1, last_acc + CMP_LAT + 1);
      i_res_valid = 1'b1;
      i_res_data  = {gold_word(0, 1), gold_word(0, 0)};
      tick();
      i_res_valid = 1'b0;
      wait_done("overrun");
      i_res_valid = 1'b1;
      repeat (3) tick();
      i_res_valid = 1'b0;
      check("report_ignores_valid_rc",   64'(o_result_count), 64'd8);
      check("report_frozen_perf",        64'(o_perf_counter), 64'd16);
      check("report_frozen_status",      64'(o_status),       64'(ST_FAIL));

      // Clean rerun from REPORT; a mid-run i_start is ignored.
      start_run(1'b0, '1);
      check("restart_rc",     64'(o_result_count),   64'd0);
      check("restart_mm",     64'(o_mismatch_count), 64'd0);
      check("restart_status", 64'(o_status),         64'(ST_RUNNING));
      send_results(NV, 4);
      push_exp(ST_PASS, 2'b00, 0, 0, 0, 8, 16, last_acc + CMP_LAT + 1, last_acc + CMP_LAT + 1);
      wait_done("rerun");

      // Stall after 4 results: watchdog.
      start_run(1'b0, '1);
      send_results(4, -1);
      push_exp(ST_TIMEOUT, 2'b00, 0, 0, 0, 4, 28, last_acc + CMP_LAT + 1, last_acc + TO + CMP_LAT + 2);
      wait_done("timeout");

      // Reset mid-run at vector 4.
      start_run(1'b0, '1);
      send_results(4, -1);
      i_res_valid = 1'b1;
      i_res_data  = {gold_word(4, 1), gold_word(4, 0)};
      reset_n = 1'b0;
      #1;
      check("midrst_status",  64'(o_status),         64'(ST_IDLE));
      check("midrst_done",    64'(o_done),           64'd0);
      check("midrst_rc",      64'(o_result_count),   64'd0);
      check("midrst_addr",    64'(o_gold_addr),      64'd0);
      check("midrst_perf",    64'(o_perf_counter),   64'd0);
      check("midrst_ch_fail", 64'(o_ch_fail),        64'd0);
      tick();
      reset_n = 1'b1;
      repeat (10) tick();
      i_res_valid = 1'b0;
      repeat (30) tick();
      check("postrst_status", 64'(o_status),       64'(ST_IDLE));
      check("postrst_done",   64'(o_done),         64'd0);
      check("postrst_rc",     64'(o_result_count), 64'd0);
      check("postrst_perf",   64'(o_perf_counter), 64'd0);

      repeat (3) tick();
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/self_checker_multi.md
Name: self_checker_multi

Overview:
- Parametrised self-checking result comparator for on-chip NPU regression.
- Compares NCH lock-step result channels from the NPU output interfaces against golden vectors in external synchronous ROMs.
- Compares each channel separately instead of OR-merging channels.
- Adds:
  - optional bit-mask compare mode
  - mismatch counting
  - first-failure capture
  - overrun detection
  - a stall watchdog
  - a latched status/performance report for the board-level test harness

Parameters:
- NCH, 2: number of result channels compared in parallel.
- DW, 1024: bits per channel result (DOTW*ACCW).
- NUM_VECTORS, 512: expected results per channel.
- ADDRW, $clog2(NUM_VECTORS): golden ROM address width.
- TIMEOUT_CYCLES, 100000: cycles with no result before a timeout is declared; 0 disables the watchdog.
- TREE_LAT, $clog2(DW): register stages in each OR-reduction tree.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; arms a test run
- i_mask_en  in  1  1 = masked compare; sampled at i_start
- i_mask  in  DW  per-bit compare enable, shared by all channels; stable during the run
- i_res_valid  in  1  all channels present a result this cycle
- i_res_data  in  NCH*DW  channel c occupies bits [c*DW +: DW]
- o_gold_addr  out  ADDRW  golden ROM read address
- i_gold_data  in  NCH*DW  golden ROM q; 1-cycle read latency
- o_status  out  3  0=IDLE 1=RUNNING 2=PASS 4=FAIL 5=TIMEOUT
- o_done  out  1  high once the run has finished
- o_ch_fail  out  NCH  sticky per-channel mismatch flags
- o_mismatch_count  out  32  saturating count of mismatching (vector, channel) pairs
- o_first_fail_idx  out  ADDRW  vector index of the first mismatch
- o_first_fail_ch  out  $clog2(NCH) (min 1)  lowest failing channel at that index
- o_result_count  out  32  results accepted
- o_perf_counter  out  32  cycles from i_start to o_done

Behaviour:
- Reset: all outputs and registers go to 0; state IDLE.
- FSM states: IDLE, RUN, DRAIN, REPORT.
  - IDLE -> RUN on i_start. Clears counters, flags, first-fail capture and the watchdog. Latches i_mask_en.
  - RUN -> DRAIN when the accepted count reaches NUM_VECTORS.
  - DRAIN -> REPORT after CMP_LAT cycles, so every compare has retired.
  - REPORT is terminal: o_done=1 and all outputs frozen. i_start restarts the run (REPORT -> RUN).
- o_status:
  - RUNNING in RUN and DRAIN.
  - In REPORT: TIMEOUT if the watchdog fired, else FAIL if o_mismatch_count != 0 or overrun occurred, else PASS.
- Accept: i_res_valid in RUN increments the index. o_gold_addr is the registered index, so ROM q for result t is valid at t+1.
- Compare pipeline:
  - Stage 1 registers i_res_data.
  - Stage 2 registers (res ^ gold) & (mask_en ? i_mask : all-ones) per channel.
  - TREE_LAT OR stages per channel.
  - Total CMP_LAT = 2 + TREE_LAT cycles from accept to per-channel fail bit. Index and valid travel alongside the data.
- On a retiring compare:
  - o_mismatch_count += popcount(fail bits), saturating at 2^32-1.
  - o_ch_fail |= fail bits.
  - The first retiring compare with any fail bit set captures index and lowest set channel; later failures never overwrite the capture.
- i_res_valid in IDLE or REPORT: ignored, not counted.
- i_res_valid in DRAIN is an overrun: sets a sticky overrun flag, forces FAIL, is not compared.
- Watchdog:
  - Counts RUN cycles without i_res_valid; resets on each accept.
  - At TIMEOUT_CYCLES it forces DRAIN with the timeout flag set. The result is then reported with the partial counts.
- o_perf_counter increments in RUN and DRAIN and holds in REPORT.
- o_result_count increments on every accept.
- i_start during RUN or DRAIN: ignored.
- reset_n low mid-run: immediate return to IDLE with all outputs 0. In-flight compares are discarded.

Decomposition:
- Package self_checker_pkg:
  - status encodings
  - FSM state enum
  - CMP_LAT function of DW
  - saturating-add helper
- Sub-module or_reduce_pipe:
  - parametrised DW
  - registered binary OR tree with valid pass-through, TREE_LAT stages
  - pads non-power-of-two widths with zeros
  - asynchronous active-low reset
  - instantiated NCH times

Test Plan:
- NCH=2, DW=64, NUM_VECTORS=8, all results equal golden, one result every cycle -> o_status=2, o_mismatch_count=0, o_result_count=8, o_done at accept-of-last + CMP_LAT + 1.
- Same run but channel 1 vector 3 bit 5 flipped, and channel 0 vector 6 flipped -> status=4, o_ch_fail=2'b11, o_mismatch_count=2, o_first_fail_idx=3, o_first_fail_ch=1.
- i_mask_en=1 with i_mask bit 5 cleared and only bit 5 flipped in vector 3 -> status=2, count=0. Repeat with i_mask_en=0 -> status=4.
- TIMEOUT_CYCLES=16, stop after 4 results -> status=5 within 16+CMP_LAT+2 cycles of last accept, o_result_count=4.
- Ninth valid during DRAIN -> status=4, o_result_count=8. Then i_start with a clean rerun -> status=2, counters restart from 0.
- reset_n pulsed low at vector 4 -> all outputs 0 immediately, no further status change until next i_start.
